// File: rtl/in_flight_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : in_flight_issue_arbiter_if
// Brief    : Request, downstream and tracker-push signals of the issue arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface in_flight_issue_arbiter_if #(
    parameter int COLORS     = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int LOG2_COLORS = $clog2(COLORS);

    logic [COLORS-1:0]            req_valid;
    logic [COLORS*DATA_WIDTH-1:0] req_data;
    logic [COLORS-1:0]            req_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [LOG2_COLORS-1:0]       out_tag;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         push;
    logic [LOG2_COLORS-1:0]       push_tag;
    logic                         tracker_ready;

    // master is the arbiter; slave is the requesters, memory side and tracker
    modport master (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        input  out_ready,
        output out_tag,
        output out_data,
        output push,
        output push_tag,
        input  tracker_ready
    );

    modport slave (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        output out_ready,
        input  out_tag,
        input  out_data,
        input  push,
        input  push_tag,
        output tracker_ready
    );
endinterface
`default_nettype wire

// File: rtl/in_flight_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : in_flight_issue_arbiter
// Brief    : Round-robin issue arbiter gated by in_flight_tracker credit.
//            Optional IN_FLIGHT_ISSUE_ARB_STALL_STATS_EN adds stall_count.
// Revision : 1.0  initial release
// ============================================================================
module in_flight_issue_arbiter #(
    parameter int COLORS     = 4,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    in_flight_issue_arbiter_if.master  bus
`ifdef IN_FLIGHT_ISSUE_ARB_STALL_STATS_EN
    ,
    output logic [15:0]                stall_count
`endif
);
    localparam int LOG2_COLORS = $clog2(COLORS);
    localparam logic [LOG2_COLORS-1:0] c_tag_one = LOG2_COLORS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LOG2_COLORS-1:0]  r_rr_ptr;
    logic [LOG2_COLORS-1:0]  w_rr_ptr_next;
    logic [LOG2_COLORS-1:0]  r_cand;
    logic [LOG2_COLORS-1:0]  w_cand_next;
    logic [LOG2_COLORS-1:0]  r_out_tag;
    logic [LOG2_COLORS-1:0]  w_out_tag_next;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [DATA_WIDTH-1:0]   w_out_data_next;

    logic [LOG2_COLORS-1:0]  w_search_base;
    logic [LOG2_COLORS-1:0]  w_idx;
    logic [LOG2_COLORS-1:0]  w_pick;
    logic                    w_found;
    logic [COLORS-1:0]       w_req_ready;
    logic                    w_out_valid;
    logic                    w_push;
    logic [DATA_WIDTH-1:0]   w_req_data [COLORS];

    genvar gc;
    generate
        for (gc = 0; gc < COLORS; gc++) begin : g_slice
            assign w_req_data[gc] = bus.req_data[gc*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // In IDLE the search starts at rr_ptr; a failed probe resumes strictly
    // after the candidate so every requester gets probed in turn.
    always_comb begin
        w_search_base = (r_state == ST_PROBE) ? (r_cand + c_tag_one) : r_rr_ptr;
        w_found       = 1'b0;
        w_pick        = w_search_base;
        w_idx         = w_search_base;
        for (int i = COLORS - 1; i >= 0; i--) begin
            w_idx = w_search_base + i[LOG2_COLORS-1:0];
            if (bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rr_ptr_next   = r_rr_ptr;
        w_cand_next     = r_cand;
        w_out_tag_next  = r_out_tag;
        w_out_data_next = r_out_data;
        w_req_ready     = '0;
        w_out_valid     = 1'b0;
        w_push          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_cand_next  = w_pick;
                    w_state_next = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (bus.tracker_ready) begin
                    w_out_data_next = w_req_data[r_cand];
                    w_out_tag_next  = r_cand;
                    w_state_next    = ST_OFFER;
                end else if (w_found) begin
                    w_cand_next = w_pick;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OFFER: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_push              = 1'b1;
                    w_req_ready[r_cand] = 1'b1;
                    w_rr_ptr_next       = r_cand + c_tag_one;
                    w_state_next        = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_cand     <= '0;
            r_out_tag  <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_cand     <= w_cand_next;
            r_out_tag  <= w_out_tag_next;
            r_out_data <= w_out_data_next;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.push      = w_push;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_data  = r_out_data;
    assign bus.push_tag  = r_cand;

`ifdef IN_FLIGHT_ISSUE_ARB_STALL_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if ((r_state == ST_PROBE) && !bus.tracker_ready
                     && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
